// File: rtl/cic_integrator_decimator.sv
// Integrator and downsampler half of a CIC decimator: STAGES wrap-around integrators at the
// input rate, emitting one full-precision sample plus a one-cycle strobe every R input strobes.
module cic_integrator_decimator #(
    parameter  int INPUT_WIDTH = 16,
    parameter  int STAGES      = 4,
    parameter  int RATE_WIDTH  = 8,
    localparam int ACC_WIDTH   = INPUT_WIDTH + STAGES * RATE_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [RATE_WIDTH-1:0]  rate,
    input  logic                   strobe_in,
    input  logic [INPUT_WIDTH-1:0] d_in,
    output logic                   strobe_out,
    output logic [ACC_WIDTH-1:0]   d_out
);

    localparam logic [RATE_WIDTH:0] RATE_ONE = 1;

    logic [ACC_WIDTH-1:0]  acc_q [STAGES];
    logic [ACC_WIDTH-1:0]  acc_d [STAGES];
    logic [RATE_WIDTH:0]   count_q, count_d;
    logic [RATE_WIDTH:0]   rate_q, rate_d;
    logic [ACC_WIDTH-1:0]  dout_q, dout_d;
    logic                  strobe_q, strobe_d;
    logic [RATE_WIDTH:0]   rate_sel;
    logic [ACC_WIDTH-1:0]  d_in_ext;
    logic                  last_sample;

    // The counter is one bit wider than the rate port so that rate_q compares exactly
    assign rate_sel    = ({1'b0, rate} <= RATE_ONE) ? RATE_ONE : {1'b0, rate};
    assign d_in_ext    = {{(ACC_WIDTH - INPUT_WIDTH){d_in[INPUT_WIDTH-1]}}, d_in};
    assign last_sample = (count_q == (rate_q - RATE_ONE));

    always_comb begin
        acc_d    = acc_q;
        count_d  = count_q;
        rate_d   = rate_q;
        dout_d   = dout_q;
        strobe_d = 1'b0;
        if (!enable) begin
            for (int k = 0; k < STAGES; k++) begin
                acc_d[k] = '0;
            end
            count_d = '0;
            rate_d  = rate_sel;
            dout_d  = '0;
        end else if (strobe_in) begin
            // Every stage adds the previous stage's old value: one pipeline register per stage
            acc_d[0] = acc_q[0] + d_in_ext;
            for (int k = 1; k < STAGES; k++) begin
                acc_d[k] = acc_q[k] + acc_q[k-1];
            end
            if (last_sample) begin
                count_d  = '0;
                dout_d   = acc_q[STAGES-1];
                strobe_d = 1'b1;
                rate_d   = rate_sel;
            end else begin
                count_d = count_q + RATE_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                acc_q[k] <= '0;
            end
            count_q  <= '0;
            rate_q   <= RATE_ONE;
            dout_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                acc_q[k] <= acc_d[k];
            end
            count_q  <= count_d;
            rate_q   <= rate_d;
            dout_q   <= dout_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobe_out = strobe_q;
    assign d_out      = dout_q;

endmodule
